mem_stage_sized: RTL

Parametrised successor to the pipeline memory stage. It provides byte-addressed data memory with RV32 sized loads and stores (byte, half and word), sign or zero extension on loads, and byte-lane write enables. Misaligned and illegal-size accesses are detected and reported. It sits between execute and writeback and includes a MEM/WB pipeline register with stall and flush control.

---
 rtl/mem_stage_sized.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_sized.sv
// Memory stage with a byte-addressed data RAM, RV32 sized loads/stores and a MEM/WB register.
// Misaligned or illegal-size accesses raise a fault that suppresses the store and the register write.
module mem_stage_sized #(
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ALUresultM,
    input  logic [31:0]           WriteDataM,
    input  logic [31:0]           PCplus4M,
    input  logic [4:0]            RdM,
    input  logic [2:0]            funct3M,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemwriteM,
    input  logic                  MemReadM,
    input  logic                  StallW,
    input  logic                  FlushW,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           ALUresultW,
    output logic [31:0]           PCplus4W,
    output logic [4:0]            RdW,
    output logic                  FaultW
);
    localparam int IDX = $clog2(MEM_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    logic [IDX-1:0] wordIdx;
    logic [1:0]     lane;
    logic [31:0]    rdWord;
    logic [7:0]     rdByte;
    logic [15:0]    rdHalf;
    logic           sizeBad;
    logic           fault;
    logic [3:0]     byteEn;
    logic [31:0]    wrLanes;
    logic [31:0]    loadData;
    logic [31:0]    aluExt;
    logic           memWrEn;

    assign wordIdx = ALUresultM[IDX+1:2];
    assign lane    = ALUresultM[1:0];
    assign aluExt  = 32'(ALUresultM);

    always_comb begin
        sizeBad = 1'b1;
        unique case (funct3M)
            F3_B:    sizeBad = 1'b0;
            F3_H:    sizeBad = lane[0];
            F3_W:    sizeBad = (lane != 2'b00);
            F3_BU:   sizeBad = MemwriteM;              // unsigned codes have no store form
            F3_HU:   sizeBad = MemwriteM | lane[0];
            default: sizeBad = 1'b1;
        endcase
        fault = (MemwriteM | MemReadM) & sizeBad;
    end

    always_comb begin
        byteEn  = 4'b0000;
        wrLanes = WriteDataM;
        unique case (funct3M)
            F3_B: begin
                byteEn  = 4'b0001 << lane;
                wrLanes = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                byteEn  = lane[1] ? 4'b1100 : 4'b0011;
                wrLanes = {2{WriteDataM[15:0]}};
            end
            F3_W: begin
                byteEn  = 4'b1111;
                wrLanes = WriteDataM;
            end
            default: begin
                byteEn  = 4'b0000;
                wrLanes = WriteDataM;
            end
        endcase
    end

    assign memWrEn = MemwriteM & ~fault & rst;

    // RAM is deliberately not reset; writes are blocked while rst is low.
    always_ff @(posedge clk) begin
        if (memWrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrLanes[8*i +: 8];
                end
            end
        end
    end

    assign rdWord = mem[wordIdx];

    always_comb begin
        rdByte = rdWord[7:0];
        unique case (lane)
            2'd0: rdByte = rdWord[7:0];
            2'd1: rdByte = rdWord[15:8];
            2'd2: rdByte = rdWord[23:16];
            2'd3: rdByte = rdWord[31:24];
        endcase
        rdHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];
    end

    always_comb begin
        loadData = 32'd0;
        unique case (funct3M)
            F3_B:    loadData = {{24{rdByte[7]}}, rdByte};
            F3_BU:   loadData = {24'd0, rdByte};
            F3_H:    loadData = {{16{rdHalf[15]}}, rdHalf};
            F3_HU:   loadData = {16'd0, rdHalf};
            F3_W:    loadData = rdWord;
            default: loadData = 32'd0;
        endcase
        if (fault || !MemReadM || !rst) begin
            loadData = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ReadDataW  <= 32'd0;
            ALUresultW <= 32'd0;
            PCplus4W   <= 32'd0;
            RdW        <= 5'd0;
            FaultW     <= 1'b0;
        end else if (FlushW) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ReadDataW  <= 32'd0;
            ALUresultW <= 32'd0;
            PCplus4W   <= 32'd0;
            RdW        <= 5'd0;
            FaultW     <= 1'b0;
        end else if (!StallW) begin
            RegWriteW  <= RegWriteM & ~fault;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= loadData;
            ALUresultW <= aluExt;
            PCplus4W   <= PCplus4M;
            RdW        <= RdM;
            FaultW     <= fault;
        end
    end

endmodule
